// File: rtl/stack_reverse_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stack_reverse_ctrl_pkg
// Shared definitions for the stack reverse controller:
//   - state_t   : controller state (CLEAR / FILL / DRAIN), 2-bit encoding
//   - DEPTH     : register file capacity in words (31)
//   - PTR_W     : width of the external up/down pointer counter (5)
//   - LAST_PTR  : counter value at which the final storable word is written
//   - top_addr(): read address of the most recently pushed word
// ---------------------------------------------------------------------------
package stack_reverse_ctrl_pkg;

    localparam int unsigned DEPTH = 31;
    localparam int unsigned PTR_W = 5;

    // The word pushed while the counter reads LAST_PTR is the 31st and last
    // one that fits.
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_FILL  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    // The counter points one past the top of stack, so the top word lives
    // one entry below it.
    function automatic logic [PTR_W-1:0] top_addr(input logic [PTR_W-1:0] cnt);
        return cnt - PTR_W'(1);
    endfunction

endpackage

// File: rtl/stack_reverse_ctrl_if.sv
// ---------------------------------------------------------------------------
// stack_reverse_ctrl_if
// Bundles every non-clock signal of the stack reverse controller:
//   in_*      : push stream from the producer (valid/ready/last + data)
//   out_*     : pop stream to the consumer (valid/ready/last + data)
//   overflow  : sticky burst-truncated flag
//   cnt_*     : commands to and status from the external pointer counter
// Modports:
//   slave  : the controller's view (consumes in_*, produces out_*, drives cnt_*)
//   master : the surrounding datapath's view (producer, consumer and counter)
// ---------------------------------------------------------------------------
interface stack_reverse_ctrl_if #(
    parameter int WIDTH = 8
);
    import stack_reverse_ctrl_pkg::*;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    logic             overflow;

    logic             cnt_up;
    logic             cnt_down;
    logic             cnt_clr;
    logic [PTR_W-1:0] cnt_value;
    logic             cnt_zero;

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready,
        output out_data, out_valid, out_last,
        input  out_ready,
        output overflow,
        output cnt_up, cnt_down, cnt_clr,
        input  cnt_value, cnt_zero
    );

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  out_data, out_valid, out_last,
        output out_ready,
        input  overflow,
        input  cnt_up, cnt_down, cnt_clr,
        output cnt_value, cnt_zero
    );

endinterface

// File: rtl/stack_reverse_ctrl_regfile.sv
// ---------------------------------------------------------------------------
// stack_regfile
// DEPTH x WIDTH storage for the stack: one synchronous write port and one
// asynchronous (combinational) read port.
// Ports:
//   clk      : rising-edge clock for the write port
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address (out-of-range addresses read as zero)
//   o_rdata  : read data
// ---------------------------------------------------------------------------
module stack_regfile
    import stack_reverse_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; stale contents are never exposed because
    // the controller only reads entries written during the current burst.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < PTR_W'(DEPTH))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A 5-bit address can name entry 31, which does not exist.
    assign o_rdata = (i_raddr < PTR_W'(DEPTH)) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/stack_reverse_ctrl.sv
// ---------------------------------------------------------------------------
// stack_reverse_ctrl
// Collects a burst of up to 31 words into a register file addressed by an
// external 5-bit up/down counter, then replays them last-in first-out.
// The controller drives the counter's up/down/clear commands and reads back
// its value and zero flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset; all outputs read 0 while asserted
//   bus  : stack_reverse_ctrl_if.slave (push stream, pop stream, overflow,
//          counter commands and status)
// ---------------------------------------------------------------------------
module stack_reverse_ctrl
    import stack_reverse_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    stack_reverse_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_overflow;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_out_last;
    logic             w_cnt_clr;
    logic             w_push;
    logic             w_pop;
    logic             w_at_cap;
    logic [WIDTH-1:0] w_rd_data;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; combinational blocks below use blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_CLEAR: w_next_state = ST_FILL;
            ST_FILL: begin
                // A non-last push at LAST_PTR stores word 31 and ends the
                // burst as if it had been marked last.
                if (w_push && (bus.in_last || w_at_cap)) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // An empty stack in DRAIN cannot happen in normal flow; leave
                // rather than pop from below entry 0.
                if (bus.cnt_zero || (w_pop && w_out_last)) begin
                    w_next_state = ST_CLEAR;
                end
            end
            default: w_next_state = ST_CLEAR;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (Moore outputs plus handshake-qualified counter commands)
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_cnt_clr   = 1'b0;
        // Outputs are forced low for as long as reset is held, not just until
        // the first clock edge.
        if (rst) begin
            unique case (r_state)
                ST_CLEAR: w_cnt_clr = 1'b1;
                ST_FILL:  w_in_ready = 1'b1;
                ST_DRAIN: begin
                    w_out_valid = !bus.cnt_zero;
                    w_out_last  = !bus.cnt_zero && (bus.cnt_value == PTR_W'(1));
                end
                default: ;
            endcase
        end
    end

    assign w_push   = w_in_ready & bus.in_valid;
    assign w_pop    = w_out_valid & bus.out_ready;
    assign w_at_cap = (bus.cnt_value == LAST_PTR);

    // Commands are exclusive by construction: each is qualified by a
    // different state.
    assign bus.cnt_clr   = w_cnt_clr;
    assign bus.cnt_up    = w_push;
    assign bus.cnt_down  = w_pop;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_last;
    assign bus.out_data  = w_out_valid ? w_rd_data : '0;
    assign bus.overflow  = r_overflow;

    // -----------------------------------------------------------------------
    // Sticky overflow: set when a burst is truncated, held through DRAIN and
    // CLEAR, dropped on the way into FILL.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_overflow <= 1'b0;
        end else if (w_push && !bus.in_last && w_at_cap) begin
            r_overflow <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Storage: write at the counter, read just below it
    // -----------------------------------------------------------------------
    stack_regfile #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (bus.cnt_value),
        .i_wdata (bus.in_data),
        .i_raddr (top_addr(bus.cnt_value)),
        .o_rdata (w_rd_data)
    );

endmodule
